// File: rtl/fpu_out_fmac.sv
// FMAC output stage: packs the IEEE-754 result, derives exception flags and buffers
// results in a 2-entry skid buffer. FPU_FMAC_ACCRUED_FLAGS_EN enables the accrued flag register.
module fpu_out_fmac #(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      In_valid_SI,
    output logic                      In_ready_SO,
    input  logic [C_MANT-1:0]         Mant_res_DI,
    input  logic [C_EXP-1:0]          Exp_res_DI,
    input  logic                      Sign_res_DI,
    input  logic                      Exp_OF_SI,
    input  logic                      Exp_UF_SI,
    input  logic                      Flag_Inexact_SI,
    input  logic                      Flag_Invalid_SI,
    input  logic                      Special_SI,
    input  logic                      Flush_SI,
    output logic                      Out_valid_SO,
    input  logic                      Out_ready_SI,
    output logic [C_EXP+C_MANT:0]     Result_DO,
    output logic [4:0]                Flags_DO,
    input  logic                      Flags_clear_SI,
    output logic [4:0]                Status_flags_DO
);

    localparam int C_W = C_EXP + C_MANT + 1;
    localparam int C_E = C_W + 5;
    localparam logic [C_W-1:0] QNAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Entry layout: {result, NV, DZ, OF, UF, NX}; exact specials and invalids raise no OF/UF/NX.
    function automatic logic [C_E-1:0] pack_entry(
        input logic              sign,
        input logic [C_EXP-1:0]  expo,
        input logic [C_MANT-1:0] mant,
        input logic              of_raw,
        input logic              uf_raw,
        input logic              nx_raw,
        input logic              nv_raw,
        input logic              special
    );
        logic           ok;
        logic [C_W-1:0] res;
        ok = ~special & ~nv_raw;
        if (nv_raw) begin
            res = QNAN;
        end else begin
            res = {sign, expo, mant};
        end
        return {res, nv_raw, 1'b0, of_raw & ok, uf_raw & nx_raw & ok, (nx_raw | of_raw) & ok};
    endfunction

    state_e         state_q, state_d;
    logic [C_E-1:0] main_q, main_d;
    logic [C_E-1:0] skid_q, skid_d;
    logic [C_E-1:0] in_entry_s;
    logic           accept_s;
    logic           drain_s;

    assign in_entry_s = pack_entry(Sign_res_DI, Exp_res_DI, Mant_res_DI, Exp_OF_SI,
                                   Exp_UF_SI, Flag_Inexact_SI, Flag_Invalid_SI, Special_SI);

    assign In_ready_SO  = (state_q != ST_FULL);
    assign Out_valid_SO = (state_q != ST_EMPTY);
    assign accept_s     = In_valid_SI & In_ready_SO;
    assign drain_s      = Out_valid_SO & Out_ready_SI;
    assign Result_DO    = main_q[C_E-1:5];
    assign Flags_DO     = main_q[4:0];

    // Occupancy FSM and entry movement; main always holds the oldest entry.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_ONE;
                    main_d  = in_entry_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    main_d = in_entry_s;
                end else if (accept_s) begin
                    state_d = ST_FULL;
                    skid_d  = in_entry_s;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (Flush_SI) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // Buffer state and entry registers.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_EMPTY;
            main_q  <= {C_E{1'b0}};
            skid_q  <= {C_E{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FPU_FMAC_ACCRUED_FLAGS_EN
    logic [4:0] status_q, status_d;

    // Clear takes effect before the drained entry's flags are merged in.
    always_comb begin
        status_d = status_q;
        if (Flags_clear_SI) begin
            status_d = 5'b00000;
        end else begin
            status_d = status_q;
        end
        if (drain_s) begin
            status_d = status_d | main_q[4:0];
        end else begin
            status_d = status_d;
        end
    end

    // Accrued flag register.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            status_q <= 5'b00000;
        end else begin
            status_q <= status_d;
        end
    end

    assign Status_flags_DO = status_q;
`else
    logic unused_flags_clear_s;
    assign unused_flags_clear_s = Flags_clear_SI;
    assign Status_flags_DO      = 5'b00000;
`endif

endmodule

// File: tb/tb_fpu_out_fmac.sv
// Scoreboard bench for fpu_out_fmac: directed scenarios plus randomized traffic
// checked against a behavioural IEEE flag/packing model and a queue-based buffer model.
module tb_fpu_out_fmac;

    logic        Clk_CI = 1'b0;
    logic        Rst_RBI;
    logic        In_valid_SI;
    logic        In_ready_SO;
    logic [22:0] Mant_res_DI;
    logic [7:0]  Exp_res_DI;
    logic        Sign_res_DI;
    logic        Exp_OF_SI;
    logic        Exp_UF_SI;
    logic        Flag_Inexact_SI;
    logic        Flag_Invalid_SI;
    logic        Special_SI;
    logic        Flush_SI;
    logic        Out_valid_SO;
    logic        Out_ready_SI;
    logic [31:0] Result_DO;
    logic [4:0]  Flags_DO;
    logic        Flags_clear_SI;
    logic [4:0]  Status_flags_DO;

    fpu_out_fmac dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .In_valid_SI(In_valid_SI), .In_ready_SO(In_ready_SO),
        .Mant_res_DI(Mant_res_DI), .Exp_res_DI(Exp_res_DI), .Sign_res_DI(Sign_res_DI),
        .Exp_OF_SI(Exp_OF_SI), .Exp_UF_SI(Exp_UF_SI),
        .Flag_Inexact_SI(Flag_Inexact_SI), .Flag_Invalid_SI(Flag_Invalid_SI),
        .Special_SI(Special_SI), .Flush_SI(Flush_SI),
        .Out_valid_SO(Out_valid_SO), .Out_ready_SI(Out_ready_SI),
        .Result_DO(Result_DO), .Flags_DO(Flags_DO),
        .Flags_clear_SI(Flags_clear_SI), .Status_flags_DO(Status_flags_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_entry;
    logic [4:0]  st_model = 5'b0;
    logic        rand_en  = 1'b0;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Reference: IEEE-754 single result word with {NV,DZ,OF,UF,NX}.
    function automatic logic [36:0] ref_model(input logic s, input logic [7:0] e, input logic [22:0] m,
                                              input logic of_r, input logic uf_r, input logic nx_r,
                                              input logic nv_r, input logic sp);
        logic [4:0] fl;
        if (nv_r) return {32'h7FC00000, 5'b10000};
        if (sp) return {s, e, m, 5'b00000};
        fl = 5'b00000;
        if (of_r) fl = fl | 5'b00101;            // overflow is always inexact
        if (nx_r) fl = fl | 5'b00001;
        if (uf_r && nx_r) fl = fl | 5'b00010;    // tiny and inexact
        return {s, e, m, fl};
    endfunction

    // Buffer model and monitor: compares outputs, then updates model for the coming edge.
    always @(negedge Clk_CI) begin
        int         occ;
        logic [36:0] e;
        if (!Rst_RBI) begin
            sb.delete();
            st_model = 5'b0;
        end else begin
            occ = sb.size();
            check("in_ready", 37'(In_ready_SO), 37'(occ < 2));
            check("out_valid", 37'(Out_valid_SO), 37'(occ != 0));
            check("status", 37'(Status_flags_DO), 37'(st_model));
            if (occ != 0 && Out_ready_SI) begin
                e = sb.pop_front();
                check("result", 37'(Result_DO), 37'(e[36:5]));
                check("flags", 37'(Flags_DO), 37'(e[4:0]));
`ifdef FPU_FMAC_ACCRUED_FLAGS_EN
                if (Flags_clear_SI) st_model = 5'b0;
                st_model = st_model | e[4:0];
            end else if (Flags_clear_SI) begin
                st_model = 5'b0;
`endif
            end
            if (Flush_SI) sb.delete();
            else if (In_valid_SI && occ < 2) sb.push_back(exp_entry);
        end
    end

    // Random consumer backpressure and flag clears during the random phase.
    initial begin
        forever begin
            @(posedge Clk_CI);
            #1;
            if (rand_en) begin
                Out_ready_SI   = ($urandom_range(0, 3) != 0);
                Flags_clear_SI = ($urandom_range(0, 15) == 0);
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [22:0] m,
                        input logic of_r, input logic uf_r, input logic nx_r,
                        input logic nv_r, input logic sp, input logic [36:0] expv);
        int waited = 0;
        Sign_res_DI = s; Exp_res_DI = e; Mant_res_DI = m;
        Exp_OF_SI = of_r; Exp_UF_SI = uf_r; Flag_Inexact_SI = nx_r;
        Flag_Invalid_SI = nv_r; Special_SI = sp;
        exp_entry = expv;
        In_valid_SI = 1'b1;
        @(negedge Clk_CI);
        while (!In_ready_SO && waited < 50) begin
            waited++;
            @(negedge Clk_CI);
        end
        if (waited >= 50) check("send_timeout", 37'(1), 37'(0));
        @(posedge Clk_CI);
        #1;
        In_valid_SI = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge Clk_CI);
            n++;
        end
        if (n >= 200) check("idle_timeout", 37'(sb.size()), 37'(0));
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic send_rand();
        logic s, of_r, uf_r, nx_r, nv_r, sp;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom); e = 8'($urandom); m = 23'($urandom);
        of_r = ($urandom_range(0, 3) == 0); uf_r = ($urandom_range(0, 2) == 0);
        nx_r = ($urandom_range(0, 1) == 0); nv_r = ($urandom_range(0, 7) == 0);
        sp = ($urandom_range(0, 5) == 0);
        send(s, e, m, of_r, uf_r, nx_r, nv_r, sp, ref_model(s, e, m, of_r, uf_r, nx_r, nv_r, sp));
    endtask

    initial begin
        logic [4:0] st_saved;
        Rst_RBI = 1'b0; In_valid_SI = 1'b0; Flush_SI = 1'b0; Out_ready_SI = 1'b1;
        Flags_clear_SI = 1'b0; Sign_res_DI = 1'b0; Exp_res_DI = 8'h0; Mant_res_DI = 23'h0;
        Exp_OF_SI = 1'b0; Exp_UF_SI = 1'b0; Flag_Inexact_SI = 1'b0; Flag_Invalid_SI = 1'b0;
        Special_SI = 1'b0; exp_entry = 37'h0;
        #12;
        check("rst_out_valid", 37'(Out_valid_SO), 37'(0));
        check("rst_in_ready", 37'(In_ready_SO), 37'(1));
        check("rst_result", 37'(Result_DO), 37'(0));
        check("rst_flags", 37'(Flags_DO), 37'(0));
        check("rst_status", 37'(Status_flags_DO), 37'(0));
        @(posedge Clk_CI); #1 Rst_RBI = 1'b1;

        // Normal result, one-cycle latency
        send(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {32'h40400000, 5'b00000});
        check("lat_valid", 37'(Out_valid_SO), 37'(1));
        check("lat_result", 37'(Result_DO), 37'(32'h40400000));
        // Overflow, then exact special
        send(1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {32'h7F800000, 5'b00101});
        send(1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, {32'h7F800000, 5'b00000});
        // Invalid -> canonical qNaN
        send(1'b1, 8'h12, 23'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {32'h7FC00000, 5'b10000});
        wait_idle();

        // Backpressure: A, B fill the buffer, C is held upstream
        Out_ready_SI = 1'b0;
        send(1'b0, 8'h01, 23'h00000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, 8'h01, 23'h00000A, 5'b00000});
        send(1'b0, 8'h02, 23'h00000B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {1'b0, 8'h02, 23'h00000B, 5'b00001});
        check("bp_in_ready_low", 37'(In_ready_SO), 37'(0));
        fork
            send(1'b1, 8'h03, 23'h00000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 8'h03, 23'h00000C, 5'b00000});
            begin
                repeat (3) @(posedge Clk_CI);
                #2 Out_ready_SI = 1'b1;
            end
        join
        wait_idle();

        // Flush of a full buffer with a simultaneous valid input
        Out_ready_SI = 1'b0;
        send(1'b0, 8'h10, 23'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, 8'h10, 23'h1, 5'b00000});
        send(1'b0, 8'h11, 23'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, 8'h11, 23'h2, 5'b00000});
        st_saved = Status_flags_DO;
        exp_entry = 37'h0; In_valid_SI = 1'b1; Flush_SI = 1'b1;
        @(posedge Clk_CI); #1;
        In_valid_SI = 1'b0; Flush_SI = 1'b0;
        check("flush_out_valid", 37'(Out_valid_SO), 37'(0));
        check("flush_in_ready", 37'(In_ready_SO), 37'(1));
        check("flush_status", 37'(Status_flags_DO), 37'(st_saved));
        Out_ready_SI = 1'b1;

        // Accrued flags
        Flags_clear_SI = 1'b1;
        @(posedge Clk_CI); #1 Flags_clear_SI = 1'b0;
        send(1'b0, 8'h40, 23'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {1'b0, 8'h40, 23'h5, 5'b00001});
        send(1'b0, 8'h00, 23'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {1'b0, 8'h00, 23'h7, 5'b00011});
        wait_idle();
`ifdef FPU_FMAC_ACCRUED_FLAGS_EN
        check("acc_nx_uf", 37'(Status_flags_DO), 37'(5'b00011));
`else
        check("acc_off", 37'(Status_flags_DO), 37'(5'b00000));
`endif
        Out_ready_SI = 1'b0;
        send(1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {32'h7F800000, 5'b00101});
        Flags_clear_SI = 1'b1; Out_ready_SI = 1'b1;
        @(posedge Clk_CI); #1 Flags_clear_SI = 1'b0;
`ifdef FPU_FMAC_ACCRUED_FLAGS_EN
        check("acc_clear_of", 37'(Status_flags_DO), 37'(5'b00101));
`else
        check("acc_off_clear", 37'(Status_flags_DO), 37'(5'b00000));
`endif

        // Randomized traffic
        rand_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) send_rand();
            else begin @(posedge Clk_CI); #1; end
        end
        rand_en = 1'b0;
        #1 Out_ready_SI = 1'b1; Flags_clear_SI = 1'b0;
        wait_idle();

        // Asynchronous reset while a result is buffered
        Out_ready_SI = 1'b0;
        send(1'b0, 8'h55, 23'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {1'b0, 8'h55, 23'h55, 5'b00001});
        send(1'b0, 8'h66, 23'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, 8'h66, 23'h66, 5'b00000});
        #2 Rst_RBI = 1'b0;
        #1;
        check("arst_out_valid", 37'(Out_valid_SO), 37'(0));
        check("arst_in_ready", 37'(In_ready_SO), 37'(1));
        check("arst_result", 37'(Result_DO), 37'(0));
        check("arst_flags", 37'(Flags_DO), 37'(0));
        check("arst_status", 37'(Status_flags_DO), 37'(0));
        @(negedge Clk_CI);
        @(posedge Clk_CI); #1 Rst_RBI = 1'b1; Out_ready_SI = 1'b1;
        send(1'b1, 8'h7F, 23'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 8'h7F, 23'h1, 5'b00000});
        wait_idle();
        check("final_empty", 37'(sb.size()), 37'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
